// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment table,
// blank pattern and the page-select width helper.
package seg_display_pkg;

  typedef logic [3:0] nibble_t;

  // Active-low segments, bit order g..a.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int page_width(input int num_pages);
    return (num_pages > 1) ? $clog2(num_pages) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg_hex_decode
  import seg_display_pkg::*;
(
  input  nibble_t    i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed, page-selectable hex display driver with tear-free frame loads.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_CYCLES   = 262144,
  parameter int NUM_PAGES      = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 display_sel,
  input  logic [page_width(NUM_PAGES)-1:0]     page_sel,
  input  logic [4*NUM_DIGITS*NUM_PAGES-1:0]    displayed_number,
  input  logic [NUM_DIGITS-1:0]                dp_mask,
  output logic [NUM_DIGITS-1:0]                Anode_Activate,
  output logic [6:0]                           LED_out,
  output logic                                 dp_out,
  output logic                                 frame_done
);

  localparam int   PW    = page_width(NUM_PAGES);
  localparam int   PGW   = 4 * NUM_DIGITS;
  localparam int   PCW   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int   KW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic ACT_LO = 1'(SEG_ACTIVE_LOW != 0);

  logic [PCW-1:0]        r_presc;
  logic [KW-1:0]         r_k;
  logic                  r_load_pending;
  logic [PGW-1:0]        r_shadow;
  logic [NUM_DIGITS-1:0] r_dp_shadow;

  logic                  w_tc;
  logic                  w_boundary;
  logic [PGW-1:0]        w_page_word;
  logic [KW-1:0]         w_digit_pos;
  nibble_t               w_nibble;
  logic [6:0]            w_seg;
  logic                  w_blank_now;
  logic [NUM_DIGITS-1:0] w_an_low;
  logic [6:0]            w_seg_low;
  logic                  w_dp_low;

  assign w_tc       = (r_presc == PCW'(DIGIT_CYCLES - 1));
  assign w_boundary = w_tc && (r_k == KW'(NUM_DIGITS - 1));

  // Page mux; out-of-range page selects fall back to page 0.
  always_comb begin
    w_page_word = displayed_number[PGW-1:0];
    for (int p = 1; p < NUM_PAGES; p++) begin
      w_page_word = (page_sel == PW'(p)) ? displayed_number[p*PGW +: PGW] : w_page_word;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_k     <= '0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_k     <= (r_k == KW'(NUM_DIGITS - 1)) ? '0 : r_k + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Load requests are remembered and only take effect on a frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_pending <= 1'b0;
      r_shadow       <= '0;
      r_dp_shadow    <= '0;
    end else if (w_boundary && (r_load_pending || display_sel)) begin
      r_load_pending <= 1'b0;
      r_shadow       <= w_page_word;
      r_dp_shadow    <= dp_mask;
    end else if (display_sel) begin
      r_load_pending <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] r_blank;
  logic [NUM_DIGITS-1:0] w_blank_nxt;
  logic                  w_zero_run;

  // A nibble is blanked while every more significant nibble is zero too.
  always_comb begin
    w_zero_run  = 1'b1;
    w_blank_nxt = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      w_zero_run     = w_zero_run & (w_page_word[4*j +: 4] == 4'h0);
      w_blank_nxt[j] = w_zero_run & (j != 0);
    end
  end

  // Blank mask follows the shadow word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blank <= '0;
    end else if (w_boundary && (r_load_pending || display_sel)) begin
      r_blank <= w_blank_nxt;
    end
  end

  assign w_blank_now = r_blank[w_digit_pos];
`else
  assign w_blank_now = 1'b0;
`endif

  // Digit k sits at nibble NUM_DIGITS-1-k, so k=0 is the leftmost digit.
  assign w_digit_pos = KW'(NUM_DIGITS - 1) - r_k;
  assign w_nibble    = r_shadow[{w_digit_pos, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  assign w_an_low  = w_blank_now ? '1 : ~(NUM_DIGITS'(1) << w_digit_pos);
  assign w_seg_low = w_blank_now ? SEG_BLANK : w_seg;
  assign w_dp_low  = w_blank_now ? 1'b1 : ~r_dp_shadow[w_digit_pos];

  // Output stage; the XOR flips the active-low patterns for active-high panels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Anode_Activate <= {NUM_DIGITS{ACT_LO}};
      LED_out        <= {7{ACT_LO}};
      dp_out         <= ACT_LO;
      frame_done     <= 1'b0;
    end else begin
      Anode_Activate <= w_an_low ^ {NUM_DIGITS{~ACT_LO}};
      LED_out        <= w_seg_low ^ {7{~ACT_LO}};
      dp_out         <= w_dp_low ^ ~ACT_LO;
      frame_done     <= w_boundary;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized self-checking bench for seg_display_mux against a cycle-count model.
module tb_seg_display_mux;

  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int NP    = 2;
  localparam int FRAME = ND * DC;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [6:0] TB_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [3:0] TB_AN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic        clk = 1'b0;
  logic        reset;
  logic        display_sel;
  logic [0:0]  page_sel;
  logic [31:0] displayed_number;
  logic [3:0]  dp_mask;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;
  logic        dp_out;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  seg_display_mux #(
    .NUM_DIGITS     (ND),
    .DIGIT_CYCLES   (DC),
    .NUM_PAGES      (NP),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .display_sel      (display_sel),
    .page_sel         (page_sel),
    .displayed_number (displayed_number),
    .dp_mask          (dp_mask),
    .Anode_Activate   (Anode_Activate),
    .LED_out          (LED_out),
    .dp_out           (dp_out),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from the number of edges since reset.
  int          m_cyc;
  logic [15:0] m_shadow;
  logic [3:0]  m_dp;
  logic        m_pend;
  logic        m_loaded;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fd;
  logic        exp_blank;

  function automatic int digit_of(input int c);
    return (c / DC) % ND;
  endfunction

  function automatic logic [3:0] nib_of(input logic [15:0] sh, input int k);
    return 4'(sh >> (4 * (ND - 1 - k)));
  endfunction

  function automatic logic blank_of(input logic [15:0] sh, input logic ld, input int k);
    int p;
    p = ND - 1 - k;
    return BLANK_EN && ld && (p > 0) && (32'(sh) < (32'd1 << (4 * p)));
  endfunction

  function automatic logic [15:0] page_word(input logic [31:0] dn, input logic [0:0] ps);
    return (int'(ps) < NP) ? 16'(dn >> (16 * int'(ps))) : dn[15:0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc <= 0; m_shadow <= 16'h0; m_dp <= 4'h0; m_pend <= 1'b0; m_loaded <= 1'b0;
      exp_an <= 4'hF; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0; exp_blank <= 1'b0;
    end else begin
      exp_blank <= blank_of(m_shadow, m_loaded, digit_of(m_cyc));
      exp_an    <= blank_of(m_shadow, m_loaded, digit_of(m_cyc)) ? 4'hF : TB_AN[digit_of(m_cyc)];
      exp_seg   <= TB_SEG[nib_of(m_shadow, digit_of(m_cyc))];
      exp_dp    <= blank_of(m_shadow, m_loaded, digit_of(m_cyc)) ? 1'b1 : !m_dp[ND - 1 - digit_of(m_cyc)];
      exp_fd    <= ((m_cyc % FRAME) == FRAME - 1);
      if (((m_cyc % FRAME) == FRAME - 1) && (m_pend || display_sel)) begin
        m_shadow <= page_word(displayed_number, page_sel);
        m_dp     <= dp_mask;
        m_pend   <= 1'b0;
        m_loaded <= 1'b1;
      end else if (display_sel) begin
        m_pend <= 1'b1;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic test_reset();
    reset = 1'b0; display_sel = 1'b0; page_sel = 1'b0; displayed_number = 32'h0; dp_mask = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({Anode_Activate, LED_out, dp_out, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
      $display("FAIL reset: got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
               Anode_Activate, LED_out, dp_out, frame_done);
    else n_pass++;
  endtask

  task automatic test_load_scan();
    int w;
    logic [6:0] segs [4];
    segs[0] = 7'b0010010; segs[1] = 7'b0000010; segs[2] = 7'b1111000; segs[3] = 7'b0000000;
    @(negedge clk);
    reset = 1'b1; displayed_number = 32'h12345678; page_sel = 1'b0; dp_mask = 4'h0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      n_checks++;
      if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
          {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
        $display("FAIL load_scan cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      else n_pass++;
      display_sel = (i == 2);
    end
    w = 0;
    while (Anode_Activate !== 4'b1110 && w < 20) begin @(negedge clk); w++; end
    while (Anode_Activate === 4'b1110 && w < 40) begin @(negedge clk); w++; end
    n_checks++;
    if (w >= 40) $display("FAIL scan_sync: waited %0d cycles, required fewer than 40", w);
    else n_pass++;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if ({Anode_Activate, LED_out} !== {TB_AN[d], segs[d]})
          $display("FAIL scan_digit d=%0d c=%0d: got an=%b seg=%b want an=%b seg=%b",
                   d, c, Anode_Activate, LED_out, TB_AN[d], segs[d]);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_page_select();
    page_sel = 1'b1;
    for (int i = 0; i < 40; i++) begin
      display_sel = (i == 0);
      @(negedge clk);
      n_checks++;
      if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
          {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
        $display("FAIL page_sel cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      else n_pass++;
    end
    display_sel = 1'b0;
  endtask

  task automatic test_tear_free();
    int w;
    page_sel = 1'b0; displayed_number = 32'h12345678;
    w = 0;
    while (frame_done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    n_checks++;
    if (w >= 40) $display("FAIL tear_sync: waited %0d cycles, required fewer than 40", w);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_checks++;
      if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
          {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
        $display("FAIL tear_free cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      else n_pass++;
      display_sel = (i == 2);
      if (i == 4) displayed_number = 32'h0000ABCD;
      if (i >= 34) displayed_number = $urandom;
    end
  endtask

  task automatic test_frame_timing();
    int last;
    int pulses;
    bit post;
    last = -1; pulses = 0; post = 1'b0;
    dp_mask = 4'b0010;
    for (int i = 0; i < 64; i++) begin
      display_sel = (i == 0);
      @(negedge clk);
      n_checks++;
      if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
          {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
        $display("FAIL frame cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      else n_pass++;
      if (post) begin
        n_checks++;
        if (dp_out !== (Anode_Activate != 4'b1101))
          $display("FAIL dp_digit cyc=%0d: got dp=%b with an=%b want dp low only on 1101",
                   i, dp_out, Anode_Activate);
        else n_pass++;
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (i - last != FRAME)
            $display("FAIL frame_period: got %0d cycles want %0d", i - last, FRAME);
          else n_pass++;
        end
        last = i; pulses++; post = 1'b1;
      end
    end
    n_checks++;
    if (pulses != 4) $display("FAIL frame_count: got %0d pulses want 4", pulses);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int w;
    w = 0;
    while (Anode_Activate !== 4'b1101 && w < 40) begin @(negedge clk); w++; end
    n_checks++;
    if (w >= 40) $display("FAIL areset_sync: waited %0d cycles, required fewer than 40", w);
    else n_pass++;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({Anode_Activate, LED_out, dp_out, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
      $display("FAIL async_reset: got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
               Anode_Activate, LED_out, dp_out, frame_done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({Anode_Activate, LED_out, dp_out} !== {4'b0111, 7'b1000000, 1'b1})
      $display("FAIL post_reset: got an=%b seg=%b dp=%b want an=0111 seg=1000000 dp=1",
               Anode_Activate, LED_out, dp_out);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
          {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
        $display("FAIL after_reset cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 240; i++) begin
      display_sel      = ($urandom_range(0, 7) == 0);
      page_sel         = 1'($urandom);
      dp_mask          = 4'($urandom);
      displayed_number = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h00F000F0) : $urandom;
      @(negedge clk);
      n_checks++;
      if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
          {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
        $display("FAIL random cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      else n_pass++;
    end
    display_sel = 1'b0;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    logic [31:0] vals [2];
    vals[0] = 32'h00000070; vals[1] = 32'h00000000;
    page_sel = 1'b0; dp_mask = 4'hF;
    for (int v = 0; v < 2; v++) begin
      displayed_number = vals[v];
      for (int i = 0; i < 48; i++) begin
        display_sel = (i == 0);
        @(negedge clk);
        n_checks++;
        if ({Anode_Activate, dp_out, frame_done, (exp_blank ? 7'h0 : LED_out)} !==
            {exp_an, exp_dp, exp_fd, (exp_blank ? 7'h0 : exp_seg)})
          $display("FAIL blank v=%0d cyc=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                   v, i, Anode_Activate, LED_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
        else n_pass++;
        if (i >= 24) begin
          n_checks++;
          if ((Anode_Activate == 4'b0111) || (Anode_Activate == 4'b1011) ||
              (v == 1 && Anode_Activate == 4'b1101))
            $display("FAIL blank_anode v=%0d cyc=%0d: got an=%b which must stay dark", v, i, Anode_Activate);
          else n_pass++;
        end
      end
    end
    display_sel = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0; display_sel = 1'b0; page_sel = 1'b0; displayed_number = 32'h0; dp_mask = 4'h0;
    test_reset();
    test_load_scan();
    test_page_select();
    test_tear_free();
    test_frame_timing();
    test_async_reset();
    test_random();
`ifdef LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
